// File: rtl/control_pkg.sv
// control_pkg: shared definitions for the pipelined MIPS control unit.
//   - CTRL_W and the bit offsets of every control-word field (MSB first:
//     selwsource[3] selregdest[2] writereg writeov selimregb selalushift
//     aluop[3] shiftop[2] readmem writemem selbrjumpz[2] selpctype[2]
//     compop[3] unsig)
//   - opcode / funct encodings of the decoded instruction set
//   - field code constants and the all-zero bubble word
package control_pkg;

  localparam int CTRL_W = 24;

  localparam int SELWSOURCE_LSB  = 21;
  localparam int SELREGDEST_LSB  = 19;
  localparam int WRITEREG_BIT    = 18;
  localparam int WRITEOV_BIT     = 17;
  localparam int SELIMREGB_BIT   = 16;
  localparam int SELALUSHIFT_BIT = 15;
  localparam int ALUOP_LSB       = 12;
  localparam int SHIFTOP_LSB     = 10;
  localparam int READMEM_BIT     = 9;
  localparam int WRITEMEM_BIT    = 8;
  localparam int SELBRJUMPZ_LSB  = 6;
  localparam int SELPCTYPE_LSB   = 4;
  localparam int COMPOP_LSB      = 1;
  localparam int UNSIG_BIT       = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  // opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // funct codes (op = OP_RTYPE)
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam logic [1:0] SH_SRL = 2'b00;
  localparam logic [1:0] SH_SRA = 2'b01;
  localparam logic [1:0] SH_SLL = 2'b10;

  localparam logic [2:0] CMP_EQ  = 3'b000;
  localparam logic [2:0] CMP_NE  = 3'b101;
  localparam logic [2:0] CMP_LEZ = 3'b010;
  localparam logic [2:0] CMP_GTZ = 3'b011;

  localparam logic [1:0] BJ_SEQ    = 2'b00;
  localparam logic [1:0] BJ_JUMP   = 2'b01;
  localparam logic [1:0] BJ_BRANCH = 2'b10;

  localparam logic [1:0] PC_IMM   = 2'b00;
  localparam logic [1:0] PC_RS    = 2'b01;
  localparam logic [1:0] PC_INDEX = 2'b10;

  localparam logic [1:0] REGDEST_RT = 2'b00;
  localparam logic [1:0] REGDEST_RD = 2'b01;

  localparam logic [2:0] WSRC_ALU = 3'b000;
  localparam logic [2:0] WSRC_MEM = 3'b001;

endpackage

// File: rtl/control_decode.sv
// control_decode: purely combinational op/fn decoder.
//   op, fn   : instruction opcode and funct fields
//   ctrl     : 24-bit control word (all-zero for illegal encodings)
//   illegal  : encoding is outside the decoded set
//   uses_rt  : instruction reads rt (R-type, BEQ, BNE, SW)
// selimregb = 1 selects the immediate as ALU operand B.
module control_decode
  import control_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output ctrl_t      ctrl,
  output logic       illegal,
  output logic       uses_rt
);

  always_comb begin
    ctrl    = BUBBLE;
    illegal = 1'b0;
    uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    case (op)
      OP_RTYPE: begin
        // Common R-type writer fields; JR and illegal functs clear them again.
        ctrl[SELREGDEST_LSB +: 2] = REGDEST_RD;
        ctrl[WRITEREG_BIT]        = 1'b1;
        ctrl[WRITEOV_BIT]         = 1'b1;
        case (fn)
          FN_SLLV: begin ctrl[SELALUSHIFT_BIT] = 1'b1; ctrl[SHIFTOP_LSB +: 2] = SH_SLL; end
          FN_SRLV: begin ctrl[SELALUSHIFT_BIT] = 1'b1; ctrl[SHIFTOP_LSB +: 2] = SH_SRL; end
          FN_SRAV: begin ctrl[SELALUSHIFT_BIT] = 1'b1; ctrl[SHIFTOP_LSB +: 2] = SH_SRA; end
          FN_JR: begin
            ctrl                      = BUBBLE;
            ctrl[SELBRJUMPZ_LSB +: 2] = BJ_JUMP;
            ctrl[SELPCTYPE_LSB +: 2]  = PC_RS;
          end
          FN_ADD:  begin ctrl[ALUOP_LSB +: 3] = ALU_ADD; ctrl[WRITEOV_BIT] = 1'b0; end
          FN_ADDU: begin ctrl[ALUOP_LSB +: 3] = ALU_ADD; ctrl[UNSIG_BIT] = 1'b1; end
          FN_SUB:  begin ctrl[ALUOP_LSB +: 3] = ALU_SUB; ctrl[WRITEOV_BIT] = 1'b0; end
          FN_SUBU: begin ctrl[ALUOP_LSB +: 3] = ALU_SUB; ctrl[UNSIG_BIT] = 1'b1; end
          FN_AND:  ctrl[ALUOP_LSB +: 3] = ALU_AND;
          FN_OR:   ctrl[ALUOP_LSB +: 3] = ALU_OR;
          FN_XOR:  ctrl[ALUOP_LSB +: 3] = ALU_XOR;
          FN_NOR:  ctrl[ALUOP_LSB +: 3] = ALU_NOR;
          default: begin ctrl = BUBBLE; illegal = 1'b1; end
        endcase
      end
      OP_J: begin
        ctrl[SELBRJUMPZ_LSB +: 2] = BJ_JUMP;
        ctrl[SELPCTYPE_LSB +: 2]  = PC_INDEX;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        ctrl[SELBRJUMPZ_LSB +: 2] = BJ_BRANCH;
        ctrl[SELPCTYPE_LSB +: 2]  = PC_IMM;
        case (op)
          OP_BNE:  ctrl[COMPOP_LSB +: 3] = CMP_NE;
          OP_BLEZ: ctrl[COMPOP_LSB +: 3] = CMP_LEZ;
          OP_BGTZ: ctrl[COMPOP_LSB +: 3] = CMP_GTZ;
          default: ctrl[COMPOP_LSB +: 3] = CMP_EQ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl[SELREGDEST_LSB +: 2] = REGDEST_RT;
        ctrl[WRITEREG_BIT]        = 1'b1;
        ctrl[WRITEOV_BIT]         = (op != OP_ADDI);
        ctrl[SELIMREGB_BIT]       = 1'b1;
        ctrl[UNSIG_BIT]           = (op == OP_ADDIU);
        case (op)
          OP_ANDI: ctrl[ALUOP_LSB +: 3] = ALU_AND;
          OP_ORI:  ctrl[ALUOP_LSB +: 3] = ALU_OR;
          OP_XORI: ctrl[ALUOP_LSB +: 3] = ALU_XOR;
          default: ctrl[ALUOP_LSB +: 3] = ALU_ADD;
        endcase
      end
      OP_LW: begin
        ctrl[SELWSOURCE_LSB +: 3] = WSRC_MEM;
        ctrl[SELREGDEST_LSB +: 2] = REGDEST_RT;
        ctrl[WRITEREG_BIT]        = 1'b1;
        ctrl[WRITEOV_BIT]         = 1'b1;
        ctrl[SELIMREGB_BIT]       = 1'b1;
        ctrl[ALUOP_LSB +: 3]      = ALU_ADD;
        ctrl[READMEM_BIT]         = 1'b1;
      end
      OP_SW: begin
        ctrl[SELIMREGB_BIT]  = 1'b1;
        ctrl[ALUOP_LSB +: 3] = ALU_ADD;
        ctrl[WRITEMEM_BIT]   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_pipe.sv
// control_pipe: pipelined MIPS control unit.
//   clock, reset        : clock, synchronous active-high reset
//   id_*                : instruction fields held in the IF/ID register
//   ex_redirect         : branch taken / jump resolved in EX (flushes ID)
//   stall               : hold PC and IF/ID (load-use, or any RAW if FWD_EN=0)
//   ex/mem/wb_ctrl      : control word held in ID/EX, EX/MEM, MEM/WB
//   ex/mem/wb_valid     : stage holds a real instruction
//   wb_dest             : register-file write index
//   fwd_a, fwd_b        : EX operand source, 00 regfile, 01 MEM, 10 WB
//   illegal             : one-cycle pulse when an undecodable instruction leaves ID
module control_pipe
  import control_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [5:0]        id_op,
  input  logic [5:0]        id_fn,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_redirect,
  output logic              stall,
  output ctrl_t             ex_ctrl,
  output ctrl_t             mem_ctrl,
  output ctrl_t             wb_ctrl,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_dest,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              illegal
);

  ctrl_t             dec_ctrl;
  logic              dec_illegal;
  logic              dec_uses_rt;
  logic [REG_AW-1:0] id_dest;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_dest, mem_dest;
  logic              raw_ex, raw_mem, load_use, nofwd_raw;

  control_decode u_decode (
    .op      (id_op),
    .fn      (id_fn),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .uses_rt (dec_uses_rt)
  );

  assign id_dest = (dec_ctrl[SELREGDEST_LSB +: 2] == REGDEST_RT) ? id_rt : id_rd;

  // RAW between the ID reader and the EX / MEM destination; r0 never conflicts.
  assign raw_ex  = (ex_dest != '0) &&
                   ((ex_dest == id_rs) || (dec_uses_rt && (ex_dest == id_rt)));
  assign raw_mem = (mem_dest != '0) &&
                   ((mem_dest == id_rs) || (dec_uses_rt && (mem_dest == id_rt)));

  assign load_use  = ex_ctrl[READMEM_BIT] && ex_ctrl[WRITEREG_BIT] && raw_ex;
  assign nofwd_raw = (FWD_EN == 0) &&
                     ((ex_valid && ex_ctrl[WRITEREG_BIT] && raw_ex) ||
                      (mem_valid && mem_ctrl[WRITEREG_BIT] && raw_mem));

  // A redirect squashes the ID instruction, so there is nothing to hold.
  assign stall = id_valid && !ex_redirect && (load_use || nofwd_raw);

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN != 0) begin
      if (ex_rs != '0 && mem_valid && mem_ctrl[WRITEREG_BIT] && mem_dest == ex_rs)
        fwd_a = 2'b01;
      else if (ex_rs != '0 && wb_valid && wb_ctrl[WRITEREG_BIT] && wb_dest == ex_rs)
        fwd_a = 2'b10;
      if (ex_rt != '0 && mem_valid && mem_ctrl[WRITEREG_BIT] && mem_dest == ex_rt)
        fwd_b = 2'b01;
      else if (ex_rt != '0 && wb_valid && wb_ctrl[WRITEREG_BIT] && wb_dest == ex_rt)
        fwd_b = 2'b10;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_ctrl   <= BUBBLE;
      mem_ctrl  <= BUBBLE;
      wb_ctrl   <= BUBBLE;
      ex_valid  <= 1'b0;
      mem_valid <= 1'b0;
      wb_valid  <= 1'b0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_dest   <= '0;
      mem_dest  <= '0;
      wb_dest   <= '0;
      illegal   <= 1'b0;
    end else begin
      mem_ctrl  <= ex_ctrl;
      mem_valid <= ex_valid;
      mem_dest  <= ex_dest;
      wb_ctrl   <= mem_ctrl;
      wb_valid  <= mem_valid;
      wb_dest   <= mem_dest;
      if (ex_redirect || stall) begin
        ex_ctrl  <= BUBBLE;
        ex_valid <= 1'b0;
        ex_rs    <= '0;
        ex_rt    <= '0;
        ex_dest  <= '0;
        illegal  <= 1'b0;
      end else begin
        ex_ctrl  <= dec_ctrl;
        ex_valid <= id_valid && !dec_illegal;
        ex_rs    <= id_rs;
        ex_rt    <= id_rt;
        ex_dest  <= id_dest;
        // Flag only when the instruction actually leaves ID, so a stalled
        // illegal instruction still pulses once.
        illegal  <= id_valid && dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: directed test-plan steps followed by randomized traffic,
// each cycle compared against a stage-by-stage reference model of the pipe.
module tb_control_pipe;

  // control-word layout, MSB first
  localparam int F_WR = 18;
  localparam int F_RM = 9;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [5:0]  id_op = '0, id_fn = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        ex_redirect = 1'b0;
  logic        stall;
  logic [23:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic        ex_valid, mem_valid, wb_valid;
  logic [4:0]  wb_dest;
  logic [1:0]  fwd_a, fwd_b;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  control_pipe #(.REG_AW(5), .FWD_EN(1)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_fn(id_fn),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_redirect(ex_redirect),
    .stall(stall), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .illegal(illegal)
  );

  // ---------------- reference model ----------------
  logic [23:0] e_c = '0, m_c = '0, w_c = '0;
  logic        e_v = 0, m_v = 0, w_v = 0, e_ill = 0;
  logic [4:0]  e_rs = '0, e_rt = '0, e_d = '0, m_d = '0, w_d = '0;
  logic [23:0] dw;
  logic        dill, exp_stall;
  logic [1:0]  exp_fa, exp_fb;

  // {selwsource, selregdest, writereg, writeov, selimregb, selalushift, aluop,
  //  shiftop, readmem, writemem, selbrjumpz, selpctype, compop, unsig}
  function automatic logic [23:0] pack(input int ws, rdst, wr, ov, imm, sh, alu, sop,
                                       rm, wm, bj, pc, cmp, un);
    return {ws[2:0], rdst[1:0], wr[0], ov[0], imm[0], sh[0], alu[2:0], sop[1:0],
            rm[0], wm[0], bj[1:0], pc[1:0], cmp[2:0], un[0]};
  endfunction

  function automatic logic [23:0] r_alu(input int alu, ov, un);
    return pack(0, 1, 1, ov, 0, 0, alu, 0, 0, 0, 0, 0, 0, un);
  endfunction
  function automatic logic [23:0] r_sh(input int sop);
    return pack(0, 1, 1, 1, 0, 1, 0, sop, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [23:0] i_alu(input int alu, ov, un);
    return pack(0, 0, 1, ov, 1, 0, alu, 0, 0, 0, 0, 0, 0, un);
  endfunction
  function automatic logic [23:0] br(input int cmp);
    return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b10, 0, cmp, 0);
  endfunction

  task automatic ref_decode(input logic [5:0] op, fn, output logic [23:0] w, output logic ill);
    ill = 1'b0;
    w = '0;
    if (op == 6'd0) begin
      case (fn)
        6'b000100: w = r_sh('b10);                                   // SLLV
        6'b000110: w = r_sh('b00);                                   // SRLV
        6'b000111: w = r_sh('b01);                                   // SRAV
        6'b001000: w = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); // JR
        6'b100000: w = r_alu('b010, 0, 0);                           // ADD
        6'b100001: w = r_alu('b010, 1, 1);                           // ADDU
        6'b100010: w = r_alu('b110, 0, 0);                           // SUB
        6'b100011: w = r_alu('b110, 1, 1);                           // SUBU
        6'b100100: w = r_alu('b000, 1, 0);                           // AND
        6'b100101: w = r_alu('b001, 1, 0);                           // OR
        6'b100110: w = r_alu('b101, 1, 0);                           // XOR
        6'b100111: w = r_alu('b100, 1, 0);                           // NOR
        default:   ill = 1'b1;
      endcase
    end else begin
      case (op)
        6'd2:  w = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'b10, 0, 0); // J
        6'd4:  w = br('b000);                                        // BEQ
        6'd5:  w = br('b101);                                        // BNE
        6'd6:  w = br('b010);                                        // BLEZ
        6'd7:  w = br('b011);                                        // BGTZ
        6'd8:  w = i_alu('b010, 0, 0);                               // ADDI
        6'd9:  w = i_alu('b010, 1, 1);                               // ADDIU
        6'd12: w = i_alu('b000, 1, 0);                               // ANDI
        6'd13: w = i_alu('b001, 1, 0);                               // ORI
        6'd14: w = i_alu('b101, 1, 0);                               // XORI
        6'd35: w = pack(1, 0, 1, 1, 1, 0, 'b010, 0, 1, 0, 0, 0, 0, 0); // LW
        6'd43: w = pack(0, 0, 0, 0, 1, 0, 'b010, 0, 0, 1, 0, 0, 0, 0); // SW
        default: ill = 1'b1;
      endcase
    end
  endtask

  function automatic logic [1:0] src_sel(input logic [4:0] r);
    if (r == 5'd0) return 2'b00;
    if (m_v && m_c[F_WR] && m_d == r) return 2'b01;
    if (w_v && w_c[F_WR] && w_d == r) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_comb();
    logic urt, raw;
    ref_decode(id_op, id_fn, dw, dill);
    urt = (id_op == 6'd0) || (id_op == 6'd4) || (id_op == 6'd5) || (id_op == 6'd43);
    raw = (e_d != 5'd0) && ((e_d == id_rs) || (urt && e_d == id_rt));
    exp_stall = id_valid && !ex_redirect && e_c[F_RM] && e_c[F_WR] && raw;
    exp_fa = src_sel(e_rs);
    exp_fb = src_sel(e_rt);
  endtask

  task automatic model_next();
    if (reset) begin
      e_c = '0; m_c = '0; w_c = '0; e_v = 0; m_v = 0; w_v = 0; e_ill = 0;
      e_rs = '0; e_rt = '0; e_d = '0; m_d = '0; w_d = '0;
    end else begin
      w_c = m_c; w_v = m_v; w_d = m_d;
      m_c = e_c; m_v = e_v; m_d = e_d;
      if (ex_redirect || exp_stall) begin
        e_c = '0; e_v = 0; e_rs = '0; e_rt = '0; e_d = '0; e_ill = 0;
      end else begin
        e_c = dw; e_v = id_valid && !dill; e_rs = id_rs; e_rt = id_rt;
        e_d = (dw[20:19] == 2'b01) ? id_rd : id_rt;
        e_ill = id_valid && dill;
      end
    end
  endtask

  // ---------------- driver / checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, fn,
                       input logic [4:0] rs, rt, rd, input logic redir);
    id_valid = v; id_op = op; id_fn = fn; id_rs = rs; id_rt = rt; id_rd = rd;
    ex_redirect = redir;
    #1;
    model_comb();
  endtask

  task automatic idle();
    drive(0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  task automatic chk_all();
    check("stall", stall, exp_stall);
    check("fwd_a", fwd_a, exp_fa);
    check("fwd_b", fwd_b, exp_fb);
    check("ex_ctrl", ex_ctrl, e_c);
    check("mem_ctrl", mem_ctrl, m_c);
    check("wb_ctrl", wb_ctrl, w_c);
    check("ex_valid", ex_valid, e_v);
    check("mem_valid", mem_valid, m_v);
    check("wb_valid", wb_valid, w_v);
    check("wb_dest", wb_dest, w_d);
    check("illegal", illegal, e_ill);
  endtask

  task automatic adv();
    model_next();
    @(posedge clock);
    @(negedge clock);
  endtask

  logic [5:0] op_tab[24] = '{0,0,0,0,0,0,0,0,0,0,0,0, 2,4,5,6,7,8,9,12,13,14,35,43};
  logic [5:0] fn_tab[24] = '{6'b000100,6'b000110,6'b000111,6'b001000,6'b100000,6'b100001,
                             6'b100010,6'b100011,6'b100100,6'b100101,6'b100110,6'b100111,
                             0,0,0,0,0,0,0,0,0,0,0,0};

  initial begin
    // reset
    reset = 1'b1;
    idle();
    adv();
    reset = 1'b0;
    idle(); chk_all();
    check("rst_stall", stall, 1'b0);
    check("rst_wb_dest", wb_dest, 5'd0);
    adv();

    // ADD r3,r1,r2 ; SUB r4,r3,r1 -> MEM forward, no stall
    drive(1, 6'd0, 6'b100000, 5'd1, 5'd2, 5'd3, 0); chk_all(); adv();
    drive(1, 6'd0, 6'b100010, 5'd3, 5'd1, 5'd4, 0); chk_all();
    check("addsub_stall", stall, 1'b0);
    adv();
    idle(); chk_all();
    check("sub_fwd_a", fwd_a, 2'b01);
    check("sub_aluop", ex_ctrl[14:12], 3'b110);
    check("sub_writeov", ex_ctrl[17], 1'b0);
    adv();
    for (int i = 0; i < 3; i++) begin idle(); chk_all(); adv(); end

    // LW r5,0(r1) ; ADD r6,r5,r2 -> one stall, bubble, then WB forward
    drive(1, 6'd35, 6'd0, 5'd1, 5'd5, 5'd0, 0); chk_all(); adv();
    drive(1, 6'd0, 6'b100000, 5'd5, 5'd2, 5'd6, 0); chk_all();
    check("lu_stall", stall, 1'b1);
    adv();
    drive(1, 6'd0, 6'b100000, 5'd5, 5'd2, 5'd6, 0); chk_all();
    check("lu_stall_end", stall, 1'b0);
    check("lu_bubble", ex_valid, 1'b0);
    adv();
    idle(); chk_all();
    check("lu_fwd_a", fwd_a, 2'b10);
    adv();
    for (int i = 0; i < 3; i++) begin idle(); chk_all(); adv(); end

    // redirect while a load-dependent instruction sits in ID
    drive(1, 6'd35, 6'd0, 5'd1, 5'd7, 5'd0, 0); chk_all(); adv();
    drive(1, 6'd0, 6'b100000, 5'd7, 5'd2, 5'd8, 1); chk_all();
    check("redir_stall", stall, 1'b0);
    adv();
    idle(); chk_all();
    check("redir_ex_valid", ex_valid, 1'b0);
    adv();

    // illegal opcode
    drive(1, 6'b111111, 6'd0, 5'd1, 5'd2, 5'd3, 0); chk_all(); adv();
    idle(); chk_all();
    check("ill_ex_valid", ex_valid, 1'b0);
    check("ill_ex_ctrl", ex_ctrl, 24'd0);
    check("ill_pulse", illegal, 1'b1);
    adv();
    idle(); chk_all();
    check("ill_pulse_end", illegal, 1'b0);
    adv();

    // r0 writer followed by r0 reader
    drive(1, 6'd35, 6'd0, 5'd1, 5'd0, 5'd0, 0); chk_all(); adv();
    drive(1, 6'd0, 6'b100000, 5'd0, 5'd0, 5'd9, 0); chk_all();
    check("r0_stall", stall, 1'b0);
    adv();
    idle(); chk_all();
    check("r0_fwd_a", fwd_a, 2'b00);
    check("r0_fwd_b", fwd_b, 2'b00);
    adv();

    // reset with all stages full
    for (int i = 0; i < 3; i++) begin
      drive(1, 6'd0, 6'b100000, 5'd2, 5'd3, 5'd1, 0); chk_all(); adv();
    end
    check("full_wb_valid", wb_valid, 1'b1);
    reset = 1'b1;
    drive(1, 6'd0, 6'b100000, 5'd2, 5'd3, 5'd1, 0); adv();
    reset = 1'b0;
    idle(); chk_all();
    check("mrst_ex_valid", ex_valid, 1'b0);
    check("mrst_mem_valid", mem_valid, 1'b0);
    check("mrst_wb_valid", wb_valid, 1'b0);
    check("mrst_wb_dest", wb_dest, 5'd0);
    check("mrst_stall", stall, 1'b0);
    adv();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int k;
      logic [5:0] op, fn;
      k = $urandom_range(0, 23);
      op = op_tab[k];
      fn = fn_tab[k];
      if ($urandom_range(0, 9) == 0) begin
        op = 6'($urandom_range(0, 63));
        fn = 6'($urandom_range(0, 63));
      end
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 9) != 0, op, fn, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 7) == 0);
      chk_all();
      adv();
    end
    reset = 1'b0;
    idle(); chk_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
- Pipelined successor to the single-cycle MIPS control decoder.
- Decodes op/fn in ID into a 24-bit control word, then carries it through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards (stall), branch/jump redirects (flush) and illegal encodings (bubble plus flag).
- Generates operand forwarding selects for the instruction in EX. Sits between the instruction fetch register and the datapath muxes.

Parameters:
- REG_AW, 5: register index width.
- FWD_EN, 1: 1 enables forwarding; 0 forces fwd_a/fwd_b to 00 and widens the hazard check to EX and MEM writers.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_op  in  6  opcode
- id_fn  in  6  funct field
- id_rs  in  REG_AW  source register A
- id_rt  in  REG_AW  source register B
- id_rd  in  REG_AW  destination register (R-type)
- ex_redirect  in  1  branch taken or jump resolved in EX
- stall  out  1  hold PC and the IF/ID register
- ex_ctrl  out  24  ID/EX control word
- mem_ctrl  out  24  EX/MEM control word
- wb_ctrl  out  24  MEM/WB control word
- ex_valid  out  1  EX slot holds a real instruction
- mem_valid  out  1  MEM slot holds a real instruction
- wb_valid  out  1  WB slot holds a real instruction
- wb_dest  out  REG_AW  register-file write index
- fwd_a  out  2  EX operand A source
- fwd_b  out  2  EX operand B source
- illegal  out  1  one-cycle pulse on an undecodable instruction

Behaviour:
- Control word fields, MSB first: selwsource[3], selregdest[2], writereg, writeov, selimregb, selalushift, aluop[3], shiftop[2], readmem, writemem, selbrjumpz[2], selpctype[2], compop[3], unsig.
- Every don't-care field decodes to 0. The output never carries X.
- aluop codes: AND 000, OR 001, ADD 010, NOR 100, XOR 101, SUB 110.
- shiftop codes: SRL 00, SRA 01, SLL 10.
- compop codes: EQ 000, NE 101, LEZ 010, GTZ 011.
- selbrjumpz codes: 00 sequential, 01 jump, 10 branch.
- selpctype codes: 00 PC+imm, 01 RS, 10 index.
- selregdest codes: 00 rt, 01 rd.
- selwsource codes: 000 ALU, 001 memory.
- Decoded set:
  - op 000000 with fn in {SLLV, SRLV, SRAV, JR, ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR}.
  - op in {J, BEQ, BNE, BLEZ, BGTZ, ADDI, ADDIU, ANDI, ORI, XORI, LW, SW}.
- writeov is 0 for ADD, SUB and ADDI; it is 1 for every other register-writing instruction.
- unsig is 1 for ADDU, SUBU and ADDIU.
- Any other op/fn is illegal: decodes to a bubble (all-zero word, valid 0) and pulses illegal the next cycle.
- Instruction uses rt: R-type, BEQ, BNE, SW.
- Register index 0 never creates a hazard and is never forwarded.
- EX destination: rt if selregdest=00, else rd. It travels with the control word to MEM and WB.
- Pipeline advance: EX/MEM <= ID/EX and MEM/WB <= EX/MEM every cycle, unconditionally.
- ID/EX load priority:
  1. reset
  2. ex_redirect: bubble
  3. stall: bubble
  4. decoded word, with valid = id_valid and !illegal
- Load-use stall (combinational): EX readmem & writereg & ex_dest!=0 & (ex_dest==id_rs | (uses_rt & ex_dest==id_rt)) & id_valid.
- With FWD_EN=0, stall also asserts on any RAW against a valid EX or MEM writer.
- ex_redirect forces stall=0 in the same cycle.
- Forwarding, per operand, against the EX source register:
  - 01 if MEM is a valid writer with a matching, nonzero dest.
  - else 10 if WB matches.
  - else 00.
- Reset values: all control registers 0, all valids 0, wb_dest 0, illegal 0. stall and fwd_* evaluate to 0 while the pipe is empty.
- Reset asserted mid-operation clears all stages in one cycle with no partial retire.
- Latency: decode to ex_ctrl is 1 cycle; ID to wb_ctrl is 3 cycles.

Decomposition:
- Package control_pkg holds:
  - control-word field offsets and width CTRL_W=24
  - op/fn localparams
  - aluop, shiftop, compop, selpctype and selbrjumpz code constants
  - the bubble constant
- Sub-module control_decode: purely combinational op/fn to {ctrl, illegal, uses_rt}.
- control_pipe holds the stage registers, hazard logic and forwarding logic.

Test Plan:
- ADD r3,r1,r2 then SUB r4,r3,r1 (FWD_EN=1): no stall; fwd_a=01 on the SUB's EX cycle; ex_ctrl aluop=110, writeov=0.
- LW r5,0(r1) then ADD r6,r5,r2: stall=1 for exactly one cycle; a bubble enters EX; then fwd_a=10.
- BEQ in EX with ex_redirect=1 while ID holds a LW-dependent instruction: stall=0; next ex_valid=0.
- op=111111: ex_valid=0 and ex_ctrl=0 the next cycle; illegal=1 for exactly one cycle.
- Write to r0 followed by a reader of r0: no stall; fwd_a=fwd_b=00.
- Reset asserted with all stages full: one cycle later all valids=0, wb_dest=0, stall=0.
